vga_window_ctrl: RTL and testbench
==================================

# vga_window_ctrl

- Positions and scans a 480×360 display window inside the VGA active area. The window position is set at run time from serial command bytes.
- Sits between the UART receiver and the framebuffer/pixel mux in the serial display path:
  - parses position commands into shadow registers;
  - applies them only at a frame boundary, so there is never tearing;
  - emits a registered in-window flag and a row-major pixel address for the framebuffer read port.

## Interface
- `H_ACTIVE`, 1024: horizontal active pixels.
- `V_ACTIVE`, 768: vertical active lines.
- `WIDTH`, 480: window width in pixels.
- `HEIGHT`, 360: window height in lines.
- `X_INIT`, 0: window X position after reset.
- `Y_INIT`, 0: window Y position after reset.
- `clk` in 1: pixel clock.
- `rst` in 1: asynchronous, active-high reset.
- `hc` in 11: horizontal counter from the sync generator.
- `vc` in 11: vertical counter from the sync generator.
- `rx_data` in 8: received byte.
- `rx_ready` in 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `x_pos` out 11: active window X.
- `y_pos` out 11: active window Y.
- `visible` out 1: pixel (`hc`,`vc`) of the previous cycle lies inside the window.
- `pix_addr` out 18: framebuffer address, aligned with `visible`.
- `pending` out 1: a commit is waiting for the frame boundary.

## Operation
- Command protocol, all bytes on `rx_ready`:
  - `0x58` ('X'), then hi byte (bits [2:0] used), then lo byte: loads shadow X.
  - `0x59` ('Y'): same sequence, loads shadow Y.
  - `0x43` ('C'): sets `pending`.
- Parser FSM states: `IDLE`, `GET_HI`, `GET_LO`.
  - `IDLE` --'X'/'Y'--> `GET_HI`, latching the target.
  - `IDLE` --'C'--> `IDLE`, setting `pending`.
  - `GET_HI` --any byte--> `GET_LO`, storing hi[2:0].
  - `GET_LO` --any byte--> `IDLE`, writing {hi,lo} to the target shadow register.
  - Any other byte in `IDLE` is ignored.
  - In `GET_HI`/`GET_LO` every byte is data, including 0x58/0x59/0x43.
- Clamping on the shadow write:
  - X is limited to `H_ACTIVE-WIDTH` (544).
  - Y is limited to `V_ACTIVE-HEIGHT` (408).
- A new X/Y write while `pending`=1 overwrites the shadow; the latest shadow value is what gets applied.
- Frame boundary is the cycle with `hc`==0 and `vc`==0. In that cycle, if `pending`=1:
  - shadow X/Y copy to `x_pos`/`y_pos`;
  - `pending` clears.
- Window test: `x_pos` ≤ `hc` < `x_pos+WIDTH` and `y_pos` ≤ `vc` < `y_pos+HEIGHT`. Compare at 12 bits so there is no overflow.
- Address counter:
  - clears to 0 on the frame boundary;
  - increments by 1 in each cycle the window test is true;
  - `pix_addr` shows the pre-increment value;
  - range is 0 to 172799.
- Reset values:
  - `x_pos`=`X_INIT`, `y_pos`=`Y_INIT`; shadow registers take the same values;
  - `visible`=0, `pix_addr`=0, `pending`=0;
  - FSM in `IDLE`.
- Reset in the middle of a command drops the partial command.

## Timing
- `visible` and `pix_addr` are registered: one-cycle latency from `hc`/`vc`.
- Boundary-cycle update:
  - the window test in the boundary cycle uses the pre-update `x_pos`/`y_pos`;
  - the new position takes effect from the next cycle onward.
- `pending` sets in the cycle after the 'C' strobe.
- A 'C' strobe in the boundary cycle is not applied in that frame. It waits for the next boundary.
- Shadow update occurs in the cycle after the lo-byte strobe.
- Back-to-back `rx_ready` strobes in consecutive cycles are accepted.

## Structure
- Package `vga_pkg`:
  - parser state enum;
  - command byte constants `CMD_X`, `CMD_Y`, `CMD_COMMIT`;
  - default geometry constants.
- One natural sub-module: `window_cmd_parser`, containing the FSM, shadow registers and clamping.
- Top level holds the commit/boundary logic, window compare and address counter.

## Test plan
- After reset with no commands, scan a full frame:
  - `visible` is first high for `hc`=0,`vc`=0, one cycle later;
  - 172800 visible cycles per frame;
  - last `pix_addr` is 172799.
- Send 'X',0x00,0x64 then 'C' mid-frame:
  - `pending`=1;
  - `x_pos` stays 0 until the next (0,0);
  - then `x_pos`=100 and `visible` is first high at `hc`=100.
- Send 'Y',0x07,0xFF:
  - shadow Y clamps to 408;
  - after 'C' and the boundary, `y_pos`=408 and the last visible line is 767.
- Send 'X',0x58,0x43:
  - interpreted as data, X=0x043=67 after the clamp check;
  - `pending` stays 0.
- 'C' strobe coincident with the (0,0) cycle: position unchanged for that frame and applied at the following boundary.
- Assert `rst` between the hi and lo bytes, then send a lone 0x10:
  - the byte is ignored;
  - X/Y hold `X_INIT`/`Y_INIT`;
  - FSM is in `IDLE`.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA window controller.
package vga_pkg;

    // Command parser states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GET_HI = 2'd1,
        GET_LO = 2'd2
    } parse_state_t;

    // Shadow register selected by the command byte
    typedef enum logic {
        TGT_X = 1'b0,
        TGT_Y = 1'b1
    } target_t;

    localparam logic [7:0] CMD_X      = 8'h58;
    localparam logic [7:0] CMD_Y      = 8'h59;
    localparam logic [7:0] CMD_COMMIT = 8'h43;

    localparam int unsigned DEF_H_ACTIVE = 1024;
    localparam int unsigned DEF_V_ACTIVE = 768;
    localparam int unsigned DEF_WIDTH    = 480;
    localparam int unsigned DEF_HEIGHT   = 360;

    localparam int unsigned POS_W  = 11;
    localparam int unsigned CMP_W  = 12;
    localparam int unsigned ADDR_W = 18;

    // Saturate a requested position to the largest legal origin
    function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] v,
                                                   input logic [POS_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/window_cmd_parser.sv
// Serial command parser: X/Y position bytes into clamped shadow registers,
// plus a commit request decode for 'C' received while idle.
module window_cmd_parser #(
    parameter int unsigned H_ACTIVE = vga_pkg::DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = vga_pkg::DEF_V_ACTIVE,
    parameter int unsigned WIDTH    = vga_pkg::DEF_WIDTH,
    parameter int unsigned HEIGHT   = vga_pkg::DEF_HEIGHT,
    parameter int unsigned X_INIT   = 0,
    parameter int unsigned Y_INIT   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_ready,
    output logic [10:0] o_shadow_x,
    output logic [10:0] o_shadow_y,
    output logic        o_commit
);
    import vga_pkg::*;

    localparam logic [POS_W-1:0] X_MAX = POS_W'(H_ACTIVE - WIDTH);
    localparam logic [POS_W-1:0] Y_MAX = POS_W'(V_ACTIVE - HEIGHT);

    parse_state_t     r_state;
    target_t          r_target;
    logic [2:0]       r_hi;
    logic [POS_W-1:0] r_shadow_x;
    logic [POS_W-1:0] r_shadow_y;
    logic [POS_W-1:0] w_value;

    assign w_value = {r_hi, i_rx_data};

    // Byte-driven FSM; every byte after 'X'/'Y' is data regardless of value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_target   <= TGT_X;
            r_hi       <= '0;
            r_shadow_x <= POS_W'(X_INIT);
            r_shadow_y <= POS_W'(Y_INIT);
        end else if (i_rx_ready) begin
            case (r_state)
                IDLE: begin
                    if (i_rx_data == CMD_X) begin
                        r_target <= TGT_X;
                        r_state  <= GET_HI;
                    end else if (i_rx_data == CMD_Y) begin
                        r_target <= TGT_Y;
                        r_state  <= GET_HI;
                    end
                end
                GET_HI: begin
                    r_hi    <= i_rx_data[2:0];
                    r_state <= GET_LO;
                end
                GET_LO: begin
                    if (r_target == TGT_X)
                        r_shadow_x <= clamp_pos(w_value, X_MAX);
                    else
                        r_shadow_y <= clamp_pos(w_value, Y_MAX);
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_commit   = i_rx_ready && (r_state == IDLE) && (i_rx_data == CMD_COMMIT);
    assign o_shadow_x = r_shadow_x;
    assign o_shadow_y = r_shadow_y;

endmodule

// File: rtl/vga_window_ctrl.sv
// Display window positioning and scan: frame-synchronous position commit,
// registered in-window flag and row-major framebuffer address.
module vga_window_ctrl #(
    parameter int unsigned H_ACTIVE = vga_pkg::DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = vga_pkg::DEF_V_ACTIVE,
    parameter int unsigned WIDTH    = vga_pkg::DEF_WIDTH,
    parameter int unsigned HEIGHT   = vga_pkg::DEF_HEIGHT,
    parameter int unsigned X_INIT   = 0,
    parameter int unsigned Y_INIT   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hc,
    input  logic [10:0] vc,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic [10:0] x_pos,
    output logic [10:0] y_pos,
    output logic        visible,
    output logic [17:0] pix_addr,
    output logic        pending
);
    import vga_pkg::*;

    logic [POS_W-1:0]  w_shadow_x;
    logic [POS_W-1:0]  w_shadow_y;
    logic              w_commit;
    logic              w_boundary;
    logic              w_in_win;
    logic [CMP_W-1:0]  w_hc;
    logic [CMP_W-1:0]  w_vc;
    logic [CMP_W-1:0]  w_x_lo;
    logic [CMP_W-1:0]  w_y_lo;
    logic [CMP_W-1:0]  w_x_hi;
    logic [CMP_W-1:0]  w_y_hi;
    logic [ADDR_W-1:0] w_addr_base;

    logic [POS_W-1:0]  r_x;
    logic [POS_W-1:0]  r_y;
    logic              r_pending;
    logic              r_visible;
    logic [ADDR_W-1:0] r_pix_addr;
    logic [ADDR_W-1:0] r_addr_cnt;

    window_cmd_parser #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .WIDTH    (WIDTH),
        .HEIGHT   (HEIGHT),
        .X_INIT   (X_INIT),
        .Y_INIT   (Y_INIT)
    ) u_parser (
        .clk        (clk),
        .rst        (rst),
        .i_rx_data  (rx_data),
        .i_rx_ready (rx_ready),
        .o_shadow_x (w_shadow_x),
        .o_shadow_y (w_shadow_y),
        .o_commit   (w_commit)
    );

    assign w_boundary = (hc == '0) && (vc == '0);

    // Window bounds widened by one bit so x_pos+WIDTH cannot wrap
    assign w_hc   = {1'b0, hc};
    assign w_vc   = {1'b0, vc};
    assign w_x_lo = {1'b0, r_x};
    assign w_y_lo = {1'b0, r_y};
    assign w_x_hi = w_x_lo + CMP_W'(WIDTH);
    assign w_y_hi = w_y_lo + CMP_W'(HEIGHT);
    assign w_in_win = (w_hc >= w_x_lo) && (w_hc < w_x_hi) &&
                      (w_vc >= w_y_lo) && (w_vc < w_y_hi);

    // Counter restarts at the boundary pixel itself, so that pixel can carry address 0
    assign w_addr_base = w_boundary ? '0 : r_addr_cnt;

    // Position commit at the frame boundary; a 'C' in that same cycle re-arms for the next frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x       <= POS_W'(X_INIT);
            r_y       <= POS_W'(Y_INIT);
            r_pending <= 1'b0;
        end else begin
            if (w_boundary && r_pending) begin
                r_x       <= w_shadow_x;
                r_y       <= w_shadow_y;
                r_pending <= 1'b0;
            end
            if (w_commit)
                r_pending <= 1'b1;
        end
    end

    // Registered window flag and pre-increment address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_visible  <= 1'b0;
            r_pix_addr <= '0;
            r_addr_cnt <= '0;
        end else begin
            r_visible  <= w_in_win;
            r_pix_addr <= w_addr_base;
            r_addr_cnt <= w_addr_base + ADDR_W'(w_in_win);
        end
    end

    assign x_pos    = r_x;
    assign y_pos    = r_y;
    assign visible  = r_visible;
    assign pix_addr = r_pix_addr;
    assign pending  = r_pending;

endmodule

// File: tb/tb_vga_window_ctrl.sv
// Bench for vga_window_ctrl on a reduced raster (96x24 active, 24x8 window).
module tb_vga_window_ctrl;

    localparam int HA = 96;
    localparam int VA = 24;
    localparam int WW = 24;
    localparam int HH = 8;
    localparam logic [7:0] BX = 8'h58;
    localparam logic [7:0] BY = 8'h59;
    localparam logic [7:0] BC = 8'h43;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hc = '0;
    logic [10:0] vc = '0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready = 1'b0;
    logic [10:0] x_pos;
    logic [10:0] y_pos;
    logic        visible;
    logic [17:0] pix_addr;
    logic        pending;

    vga_window_ctrl #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .WIDTH    (WW),
        .HEIGHT   (HH),
        .X_INIT   (0),
        .Y_INIT   (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .hc       (hc),
        .vc       (vc),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .x_pos    (x_pos),
        .y_pos    (y_pos),
        .visible  (visible),
        .pix_addr (pix_addr),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: window origin, shadow, pending flag, pixel count, byte buffer
    int         m_x, m_y, m_sx, m_sy, m_cnt, m_addr;
    bit         m_pend, m_vis;
    logic [7:0] m_q[$];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_sx = 0; m_sy = 0;
        m_cnt = 0; m_addr = 0; m_pend = 0; m_vis = 0;
        m_q.delete();
    endtask

    task automatic model_cycle(input int h, input int v, input bit rdy, input logic [7:0] d);
        bit inside_w;
        bit frame0;
        int val;
        frame0   = (h == 0) && (v == 0);
        inside_w = (h >= m_x) && (h < m_x + WW) && (v >= m_y) && (v < m_y + HH);
        if (frame0) m_cnt = 0;
        m_vis  = inside_w;
        m_addr = m_cnt;
        m_cnt  = m_cnt + (inside_w ? 1 : 0);
        if (frame0 && m_pend) begin
            m_x = m_sx; m_y = m_sy; m_pend = 0;
        end
        if (rdy) begin
            if (m_q.size() == 0) begin
                if (d == BX || d == BY) m_q.push_back(d);
                else if (d == BC) m_pend = 1;
            end else begin
                m_q.push_back(d);
                if (m_q.size() == 3) begin
                    val = int'(m_q[1] & 8'h07) * 256 + int'(m_q[2]);
                    if (m_q[0] == BX) m_sx = imin(val, HA - WW);
                    else              m_sy = imin(val, VA - HH);
                    m_q.delete();
                end
            end
        end
    endtask

    // Per-frame observations of the DUT
    int st_first_h, st_first_v, st_count, st_last_addr, st_last_h, st_last_v;
    int cur_h = 0, cur_v = 0;

    task automatic step(input int h, input int v, input bit rdy, input logic [7:0] d);
        logic [41:0] exp_v, act_v;
        hc = 11'(h); vc = 11'(v); rx_ready = rdy; rx_data = d;
        if (h == 0 && v == 0) begin
            st_count = 0; st_first_h = -1; st_first_v = -1;
            st_last_addr = -1; st_last_h = -1; st_last_v = -1;
        end
        @(posedge clk); #1;
        model_cycle(h, v, rdy, d);
        exp_v = {m_vis, 18'(m_addr), 11'(m_x), 11'(m_y), m_pend};
        act_v = {visible, pix_addr, x_pos, y_pos, pending};
        n_total++;
        if (exp_v == act_v) n_pass++;
        else $display("FAIL model h=%0d v=%0d: got vis=%0d addr=%0d x=%0d y=%0d pend=%0d expected vis=%0d addr=%0d x=%0d y=%0d pend=%0d",
                      h, v, visible, pix_addr, x_pos, y_pos, pending, m_vis, m_addr, m_x, m_y, m_pend);
        if (visible) begin
            if (st_count == 0) begin st_first_h = h; st_first_v = v; end
            st_count++;
            st_last_addr = int'(pix_addr);
            st_last_h = h; st_last_v = v;
        end
        rx_ready = 1'b0;
    endtask

    task automatic rstep(input bit rdy, input logic [7:0] d);
        step(cur_h, cur_v, rdy, d);
        cur_h++;
        if (cur_h == HA) begin
            cur_h = 0; cur_v++;
            if (cur_v == VA) cur_v = 0;
        end
    endtask

    task automatic send(input logic [7:0] d);
        rstep(1'b1, d);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) rstep(1'b0, 8'h00);
    endtask

    task automatic finish_frame();
        int guard;
        guard = 0;
        while (!(cur_h == 0 && cur_v == 0) && guard < HA * VA + 2) begin
            rstep(1'b0, 8'h00);
            guard++;
        end
    endtask

    task automatic full_frame();
        rstep(1'b0, 8'h00);
        finish_frame();
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #4 rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        int         h;
        int         v;
        bit         rdy;
        logic [7:0] d;
        bit         e_vis;
        int         e_addr;
        bit         e_pend;
    } vec_t;

    vec_t tv[12];

    initial begin
        tv[0]  = '{0,  0,  0, 8'h00, 1, 0, 0};
        tv[1]  = '{1,  0,  0, 8'h00, 1, 1, 0};
        tv[2]  = '{23, 0,  0, 8'h00, 1, 2, 0};
        tv[3]  = '{24, 0,  0, 8'h00, 0, 3, 0};
        tv[4]  = '{0,  7,  0, 8'h00, 1, 3, 0};
        tv[5]  = '{0,  8,  0, 8'h00, 0, 4, 0};
        tv[6]  = '{0,  0,  0, 8'h00, 1, 0, 0};
        tv[7]  = '{10, 5,  1, BC,    1, 1, 1};
        tv[8]  = '{95, 23, 0, 8'h00, 0, 2, 1};
        tv[9]  = '{0,  0,  0, 8'h00, 1, 0, 0};
        tv[10] = '{23, 7,  0, 8'h00, 1, 1, 0};
        tv[11] = '{0,  0,  1, BX,    1, 0, 0};

        do_reset();
        chk("rst_x", x_pos, 0);
        chk("rst_y", y_pos, 0);
        chk("rst_visible", visible, 0);
        chk("rst_pix_addr", pix_addr, 0);
        chk("rst_pending", pending, 0);

        // Directed single-cycle vectors
        for (int i = 0; i < 12; i++) begin
            step(tv[i].h, tv[i].v, tv[i].rdy, tv[i].d);
            chk($sformatf("tv%0d_visible", i), visible, tv[i].e_vis);
            chk($sformatf("tv%0d_addr", i), pix_addr, tv[i].e_addr);
            chk($sformatf("tv%0d_pending", i), pending, tv[i].e_pend);
            chk($sformatf("tv%0d_x", i), x_pos, 0);
        end

        // Full frame at reset position
        do_reset();
        cur_h = 0; cur_v = 0;
        full_frame();
        chk("f0_first_h", st_first_h, 0);
        chk("f0_first_v", st_first_v, 0);
        chk("f0_count", st_count, WW * HH);
        chk("f0_last_addr", st_last_addr, WW * HH - 1);

        // X move, back-to-back bytes, applied only at the next boundary
        run(100);
        send(BX); send(8'h00); send(8'h14); send(BC);
        chk("xmove_pending", pending, 1);
        chk("xmove_x_early", x_pos, 0);
        finish_frame();
        chk("xmove_x_hold", x_pos, 0);
        full_frame();
        chk("xmove_x", x_pos, 20);
        chk("xmove_pending_clr", pending, 0);
        full_frame();
        chk("xmove_first_h", st_first_h, 20);
        chk("xmove_first_v", st_first_v, 0);
        chk("xmove_count", st_count, WW * HH);
        chk("xmove_last_addr", st_last_addr, WW * HH - 1);

        // Y clamp to V_ACTIVE-HEIGHT
        run(50);
        send(BY); send(8'h07); send(8'hFF); send(BC);
        finish_frame();
        full_frame();
        chk("yclamp_y", y_pos, VA - HH);
        full_frame();
        chk("yclamp_first_v", st_first_v, VA - HH);
        chk("yclamp_last_v", st_last_v, VA - 1);
        chk("yclamp_count", st_count, WW * HH);

        // Command-looking bytes consumed as data
        run(50);
        send(BX); send(BX); send(BC);
        chk("data_bytes_pending", pending, 0);
        send(BC);
        finish_frame();
        full_frame();
        chk("data_bytes_x", x_pos, 67);
        full_frame();
        chk("data_bytes_first_h", st_first_h, 67);
        chk("data_bytes_last_h", st_last_h, 67 + WW - 1);

        // 'C' in the boundary cycle waits a full frame
        run(30);
        send(BX); send(8'h00); send(8'h05);
        finish_frame();
        send(BC);
        chk("cbnd_x_same", x_pos, 67);
        chk("cbnd_pending", pending, 1);
        finish_frame();
        chk("cbnd_x_hold", x_pos, 67);
        rstep(1'b0, 8'h00);
        chk("cbnd_x_applied", x_pos, 5);
        chk("cbnd_pending_clr", pending, 0);

        // Reset between hi and lo bytes drops the command
        run(30);
        send(BX); send(8'h00);
        do_reset();
        send(8'h10);
        chk("rstmid_x", x_pos, 0);
        chk("rstmid_y", y_pos, 0);
        chk("rstmid_pending", pending, 0);
        send(BX); send(8'h00); send(8'h07); send(BC);
        chk("rstmid_idle_pending", pending, 1);
        finish_frame();
        rstep(1'b0, 8'h00);
        chk("rstmid_idle_x", x_pos, 7);
        chk("rstmid_idle_y", y_pos, 0);

        // Random pixels and bytes against the model
        for (int i = 0; i < 4000; i++) begin
            int h, v, sel;
            bit rdy;
            logic [7:0] d;
            if ($urandom_range(0, 15) == 0) begin h = 0; v = 0; end
            else begin h = $urandom_range(0, HA - 1); v = $urandom_range(0, VA - 1); end
            rdy = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 3);
            d = (sel == 0) ? BX : (sel == 1) ? BY : (sel == 2) ? BC : 8'($urandom);
            step(h, v, rdy, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
